signed_addsub_pipe: RTL
=======================

Name: signed_addsub_pipe

Overview:
Parametrised, pipelined, multi-lane signed add/subtract unit for the geometry/raster datapath (e.g. x/y/z vertex deltas, edge-function terms). It generalises the single-lane combinational 13-bit signed subtractor in four ways: N lanes, add or subtract per transaction, three selectable overflow-handling modes, and per-lane overflow flags. A two-stage valid/ready pipeline lets it sit between stalling producers and consumers.

Parameters:
WIDTH, 13, operand/result width per lane (two's complement), legal range 4..32
LANES, 3, number of independent lanes sharing one handshake
PACKED bus layout, fixed (not a parameter): lane i occupies bits [i*WIDTH +: WIDTH]

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input transaction valid
in_ready  output  1  unit can accept input this cycle
op  input  1  0 = dataa+datab, 1 = dataa-datab (all lanes)
mode  input  2  0 = legacy, 1 = saturate, 2 = wrap, 3 = treated as wrap
dataa  input  LANES*WIDTH  signed operands A
datab  input  LANES*WIDTH  signed operands B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  LANES*WIDTH  formatted per-lane results
ovf  output  LANES  per-lane overflow, aligned with result
ovf_sticky  output  LANES  accumulated overflow since last clear
ovf_clr  input  1  clears ovf_sticky

Behaviour:
- Reset (async assert, sync-released by system): s1_valid=0, s2_valid=0, out_valid=0, result=0, ovf=0, ovf_sticky=0. in_ready reads 1 during and after reset. Reset mid-transaction drops all in-flight data, with no partial output.
- Stage 1: on in_valid && in_ready, register op, mode, and per-lane full-precision sum S = A ± B, computed at WIDTH+1 bits with sign extension.
- Stage 2: format S into WIDTH bits and register result, ovf.
- Latency: exactly 2 cycles from input acceptance to out_valid when out_ready is held high. Throughput: 1 transaction/cycle.
- Overflow: ovf[i] = 1 iff S is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1], i.e. S[WIDTH] != S[WIDTH-1]. The rule is identical in all modes.
- Formatting modes:
  - Mode 0 (legacy): result = {S[WIDTH], S[WIDTH-2:0]}. This keeps the sign and drops bit WIDTH-1, bit-exact with the existing subtractor.
  - Mode 1 (saturate): if overflow and S negative, result = -2^(WIDTH-1); if overflow and S positive, result = 2^(WIDTH-1)-1; otherwise result = S[WIDTH-1:0].
  - Mode 2 or 3 (wrap): result = S[WIDTH-1:0].
- Handshake:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational from out_ready, no registered skid)
- Holding rules:
  - While out_valid && !out_ready, result and ovf hold stable.
  - Stage 1 holds when it is full and stage 2 is stalled.
  - Input values are don't-care when in_valid=0.
- Bubbles: when stage 1 is empty and stage 2 advances, s2_valid clears. Bubbles collapse; no empty stage is held while upstream waits.
- ovf_sticky: on each output handshake (out_valid && out_ready), ovf_sticky |= ovf. ovf_clr zeroes it. If a set and ovf_clr occur in the same cycle, the set wins: the bit ends at the value of that handshake's ovf.
- Lanes are fully independent arithmetically; a carry never crosses a lane boundary.

Test Plan (WIDTH=13, LANES=3 unless stated):
1. Lane0 op=1, A=4095, B=-1 (S=4096), each mode with out_ready=1 -> ovf[0]=1 and out_valid exactly 2 cycles after acceptance. Expected result: mode0 = 0, mode1 = 4095 (0x0FFF), mode2 = -4096 (0x1000).
2. Lane1 op=1, A=-4096, B=1 (S=-4097) -> ovf[1]=1. Expected result: mode0 = 0x1FFF (-1), mode1 = 0x1000 (-4096), mode2 = 0x0FFF (4095).
3. Non-overflow add, lanes {100+(-30), -7+(-8), 0+0}, any mode -> {70, -15, 0}, ovf=000, identical across all modes.
4. Backpressure: stream 5 back-to-back transactions, out_ready low for cycles 3-6 -> in_ready drops after two entries are held, no loss or duplication, in-order outputs, result stable while stalled.
5. Sticky: overflow on lane2, then ovf_clr asserted in the same cycle as a second lane2-overflow handshake -> ovf_sticky[2] stays 1. Clear in an idle cycle -> 0.
6. Assert rst_n=0 asynchronously with 2 transactions in flight -> out_valid, result, ovf, ovf_sticky go to 0 immediately, and no stale output appears after release.

Source files
------------

// File: rtl/signed_addsub_pipe.sv
// signed_addsub_pipe: N-lane signed add/subtract with a two-stage
// valid/ready pipeline and selectable overflow formatting.
//
// Handshake: a beat transfers on a rising edge where valid && ready.
// in_ready is combinational from out_ready (no skid buffer). Once
// out_valid is high, result and ovf stay stable until out_ready is seen.
module signed_addsub_pipe #(
  parameter int WIDTH = 13,
  parameter int LANES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op,
  input  logic [1:0]             mode,
  input  logic [LANES*WIDTH-1:0] dataa,
  input  logic [LANES*WIDTH-1:0] datab,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic [LANES-1:0]       ovf,
  output logic [LANES-1:0]       ovf_sticky,
  input  logic                   ovf_clr
);

  localparam int SW = WIDTH + 1;

  logic                   r_s1_valid;
  logic [1:0]             r_s1_mode;
  logic [LANES*SW-1:0]    r_s1_sum;
  logic                   r_s2_valid;
  logic [LANES*WIDTH-1:0] r_result;
  logic [LANES-1:0]       r_ovf;
  logic [LANES-1:0]       r_sticky;

  logic                   w_s1_adv;
  logic                   w_s2_adv;
  logic                   w_out_hs;
  logic [LANES*SW-1:0]    w_sum;
  logic [LANES*WIDTH-1:0] w_fmt;
  logic [LANES-1:0]       w_ovf;

  // Bubbles collapse: an empty stage always advances.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_out_hs = r_s2_valid && out_ready;

  assign in_ready   = w_s1_adv;
  assign out_valid  = r_s2_valid;
  assign result     = r_result;
  assign ovf        = r_ovf;
  assign ovf_sticky = r_sticky;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [SW-1:0]    w_a;
    logic [SW-1:0]    w_b;
    logic [SW-1:0]    w_s;
    logic [WIDTH-1:0] w_r;

    // Sign-extend to WIDTH+1 so the sum is exact; lanes never share a carry.
    assign w_a = {dataa[i*WIDTH+WIDTH-1], dataa[i*WIDTH +: WIDTH]};
    assign w_b = {datab[i*WIDTH+WIDTH-1], datab[i*WIDTH +: WIDTH]};
    assign w_sum[i*SW +: SW] = op ? (w_a - w_b) : (w_a + w_b);

    assign w_s      = r_s1_sum[i*SW +: SW];
    assign w_ovf[i] = w_s[WIDTH] ^ w_s[WIDTH-1];

    // Format the full-precision sum into WIDTH bits according to mode.
    always_comb begin
      w_r = w_s[WIDTH-1:0];
      case (r_s1_mode)
        2'd0: w_r = {w_s[WIDTH], w_s[WIDTH-2:0]};
        2'd1: begin
          if (w_ovf[i]) begin
            w_r = w_s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
          end
        end
        default: w_r = w_s[WIDTH-1:0];
      endcase
    end

    assign w_fmt[i*WIDTH +: WIDTH] = w_r;
  end

  // Stage 1: capture mode and exact per-lane sums on input acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 2'd0;
      r_s1_sum   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_mode <= mode;
        r_s1_sum  <= w_sum;
      end
    end
  end

  // Stage 2: register formatted results and overflow flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_ovf      <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_fmt;
        r_ovf    <= w_ovf;
      end
    end
  end

  // Sticky overflow: a handshake's flags win over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= '0;
    end else if (w_out_hs) begin
      r_sticky <= ovf_clr ? r_ovf : (r_sticky | r_ovf);
    end else if (ovf_clr) begin
      r_sticky <= '0;
    end
  end

endmodule
